// File: rtl/wx_matvec_pkg.sv
// wx_matvec_pkg: shared state type and arithmetic helpers for the
// time-multiplexed W*x engine.
package wx_matvec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Full-precision accumulator width: a 2*DW product summed N times.
    function automatic int acc_w(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    // Clamp a sign-extended accumulator into the signed out_w range.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/wx_matvec_row.sv
// wx_matvec_row: one row MAC of the W*x engine. Clears on vector accept,
// accumulates w*x once per column, and converts the accumulator to OUT_W.
// Build option WX_MATVEC_SAT_EN selects clamping (with sat flag) instead
// of two's-complement wrap.
module wx_matvec_row
    import wx_matvec_pkg::*;
#(
    parameter int N     = 3,
    parameter int DW    = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [DW-1:0]    w,
    input  logic [DW-1:0]    x,
    output logic [OUT_W-1:0] s,
    output logic             sat
);
    localparam int ACC_W = acc_w(DW, N);

    logic [2*DW-1:0]          prod;
    logic signed [ACC_W-1:0]  acc;

    // Full-width signed product of the current weight and x element.
    always_comb begin
        prod = {{DW{w[DW-1]}}, w} * {{DW{x[DW-1]}}, x};
    end

    // Accumulator: zeroed on reset or accept, adds one product per MAC cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        end
    end

`ifdef WX_MATVEC_SAT_EN
    logic signed [63:0] acc_ext;
    logic signed [63:0] clamped;

    // Clamp to the OUT_W range and flag rows that needed clamping.
    always_comb begin
        acc_ext = 64'(acc);
        clamped = saturate(acc_ext, OUT_W);
        s       = clamped[OUT_W-1:0];
        sat     = (clamped != acc_ext);
    end
`else
    // Keep the low OUT_W bits; overflow wraps and is never flagged.
    always_comb begin
        s   = OUT_W'(acc);
        sat = 1'b0;
    end
`endif

endmodule

// File: rtl/wx_matvec.sv
// wx_matvec: N x N signed weight register file and time-multiplexed W*x
// engine, one column per cycle across N row MACs, valid/ready on both sides.
// Build option WX_MATVEC_SAT_EN enables output saturation.
module wx_matvec
    import wx_matvec_pkg::*;
#(
    parameter int N     = 3,
    parameter int DW    = 16,
    parameter int OUT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 w_we,
    input  logic [$clog2(N)-1:0] w_row,
    input  logic [$clog2(N)-1:0] w_col,
    input  logic [DW-1:0]        w_data,
    output logic                 w_err,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic [N*DW-1:0]      x_in,
    output logic                 s_valid,
    input  logic                 s_ready,
    output logic [N*OUT_W-1:0]   s_out,
    output logic [N-1:0]         sat
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] K_LAST = AW'(N - 1);

    state_t          state;
    state_t          next_state;
    logic [AW-1:0]   k;
    logic [N*DW-1:0] x_reg;
    logic [DW-1:0]   weights [N][N];
    logic [DW-1:0]   x_k;
    logic            accept;
    logic            mac_en;
    logic            w_ok;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: accept in IDLE, N MAC cycles, hold until consumed.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (x_valid) next_state = MAC;
            MAC:     if (k == K_LAST) next_state = HOLD;
            HOLD:    if (s_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs depend only on the registered state.
    always_comb begin
        x_ready = (state == IDLE);
        s_valid = (state == HOLD);
    end

    // Datapath controls; weight writes are legal only in IDLE and in range.
    always_comb begin
        accept = (state == IDLE) && x_valid;
        mac_en = (state == MAC);
        w_ok   = (state == IDLE)
                 && ({1'b0, w_row} < (AW+1)'(N))
                 && ({1'b0, w_col} < (AW+1)'(N));
        x_k    = x_reg[k*DW +: DW];
    end

    // Column counter and latched input vector.
    always_ff @(posedge clk) begin
        if (!reset) begin
            k     <= '0;
            x_reg <= '0;
        end else if (accept) begin
            k     <= '0;
            x_reg <= x_in;
        end else if (mac_en) begin
            k     <= k + 1'b1;
        end
    end

    // Weight register file and one-cycle error pulse for dropped writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_err <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    weights[r][c] <= '0;
                end
            end
        end else begin
            w_err <= w_we && !w_ok;
            if (w_we && w_ok) begin
                weights[w_row][w_col] <= w_data;
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        wx_matvec_row #(
            .N     (N),
            .DW    (DW),
            .OUT_W (OUT_W)
        ) u_row (
            .clk   (clk),
            .reset (reset),
            .clear (accept),
            .en    (mac_en),
            .w     (weights[r][k]),
            .x     (x_k),
            .s     (s_out[r*OUT_W +: OUT_W]),
            .sat   (sat[r])
        );
    end

endmodule

// File: tb/tb_wx_matvec.sv
// tb_wx_matvec: self-checking bench for wx_matvec. Keeps its own copy of the
// weight matrix and computes s = W*x with plain integer arithmetic.
module tb_wx_matvec;
    localparam int N     = 3;
    localparam int DW    = 16;
    localparam int OUT_W = 32;
    localparam int AW    = $clog2(N);
    localparam longint MAXV = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (OUT_W - 1));
`ifdef WX_MATVEC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               w_we;
    logic [AW-1:0]      w_row;
    logic [AW-1:0]      w_col;
    logic [DW-1:0]      w_data;
    logic               w_err;
    logic               x_valid;
    logic               x_ready;
    logic [N*DW-1:0]    x_in;
    logic               s_valid;
    logic               s_ready;
    logic [N*OUT_W-1:0] s_out;
    logic [N-1:0]       sat;

    int     total = 0;
    int     bad   = 0;
    longint mw [N][N];

    always #5 clk = ~clk;

    wx_matvec #(.N(N), .DW(DW), .OUT_W(OUT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .w_we    (w_we),
        .w_row   (w_row),
        .w_col   (w_col),
        .w_data  (w_data),
        .w_err   (w_err),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .x_in    (x_in),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_out   (s_out),
        .sat     (sat)
    );

    // Reference model: exact dot product of row r with x.
    function automatic longint model_dot(input int r, input logic [N*DW-1:0] xv);
        longint acc;
        logic signed [DW-1:0] e;
        acc = 0;
        for (int c = 0; c < N; c++) begin
            e = xv[c*DW +: DW];
            acc += mw[r][c] * longint'(e);
        end
        return acc;
    endfunction

    // Reference output conversion: clamp or wrap to OUT_W bits.
    function automatic longint convert(input longint a);
        logic signed [OUT_W-1:0] t;
        if (SAT_EN) begin
            if (a > MAXV) return MAXV;
            if (a < MINV) return MINV;
            return a;
        end
        t = a[OUT_W-1:0];
        return longint'(t);
    endfunction

    function automatic logic expect_sat(input longint a);
        return SAT_EN && ((a > MAXV) || (a < MINV));
    endfunction

    function automatic logic [N*DW-1:0] rand_vec();
        logic [N*DW-1:0] v;
        for (int c = 0; c < N; c++) v[c*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic push_weights();
        logic [DW-1:0] v;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                @(negedge clk);
                v = DW'(mw[r][c]);
                w_we = 1'b1; w_row = AW'(r); w_col = AW'(c); w_data = v;
            end
        end
        @(negedge clk);
        w_we = 1'b0;
    endtask

    // Presents one vector and returns at the negedge just after acceptance.
    task automatic accept_vector(input logic [N*DW-1:0] xv);
        int n;
        n = 0;
        @(negedge clk);
        while (!x_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!x_ready) begin
            total++; bad++;
            $display("[TB] FAIL accept_timeout x_ready got=0 want=1");
        end
        x_valid = 1'b1; x_in = xv;
        @(posedge clk);
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!s_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!s_valid) begin
            total++; bad++;
            $display("[TB] FAIL result_timeout s_valid got=0 want=1");
            lat = -1;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        s_ready = 1'b1;
        @(negedge clk);
        s_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; w_we = 1'b0; w_row = '0; w_col = '0; w_data = '0;
        x_valid = 1'b0; x_in = '0; s_ready = 1'b0;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mw[r][c] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        total++; if (x_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_x_ready got=%b want=1", x_ready); end
        total++; if (s_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_s_valid got=%b want=0", s_valid); end
        total++; if (s_out !== '0) begin bad++; $display("[TB] FAIL reset_s_out got=%h want=0", s_out); end
        total++; if (sat !== '0) begin bad++; $display("[TB] FAIL reset_sat got=%b want=0", sat); end
        total++; if (w_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_w_err got=%b want=0", w_err); end
    endtask

    task automatic test_identity();
        logic [N*DW-1:0] xv;
        longint e;
        int lat;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mw[r][c] = (r == c) ? 1 : 0;
        push_weights();
        xv[0*DW +: DW] = DW'(5);
        xv[1*DW +: DW] = DW'(-7);
        xv[2*DW +: DW] = DW'(9);
        accept_vector(xv);
        wait_result(lat);
        total++; if (lat !== N) begin bad++; $display("[TB] FAIL identity_latency got=%0d want=%0d", lat, N); end
        for (int r = 0; r < N; r++) begin
            e = convert(model_dot(r, xv));
            total++;
            if (s_out[r*OUT_W +: OUT_W] !== OUT_W'(e)) begin
                bad++; $display("[TB] FAIL identity_s%0d got=%0d want=%0d", r, $signed(s_out[r*OUT_W +: OUT_W]), e);
            end
            total++;
            if (sat[r] !== expect_sat(model_dot(r, xv))) begin
                bad++; $display("[TB] FAIL identity_sat%0d got=%b want=%b", r, sat[r], expect_sat(model_dot(r, xv)));
            end
        end
        consume();
        total++; if (s_valid !== 1'b0 || x_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL identity_release got=%b%b want=01", s_valid, x_ready);
        end
    endtask

    task automatic test_stall();
        logic [N*DW-1:0]    xv;
        logic [N*OUT_W-1:0] exp_vec;
        int lat;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mw[r][c] = r * N + c + 1;
        push_weights();
        for (int c = 0; c < N; c++) xv[c*DW +: DW] = DW'(1);
        for (int r = 0; r < N; r++) exp_vec[r*OUT_W +: OUT_W] = OUT_W'(convert(model_dot(r, xv)));
        accept_vector(xv);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (s_out !== exp_vec || s_valid !== 1'b1 || x_ready !== 1'b0) begin
                bad++; $display("[TB] FAIL stall_cycle%0d got=%h/%b/%b want=%h/1/0", i, s_out, s_valid, x_ready, exp_vec);
            end
            @(negedge clk);
        end
        consume();
    endtask

    task automatic test_overflow();
        logic [N*DW-1:0] xv;
        longint e;
        int lat;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mw[r][c] = -32768;
        push_weights();
        for (int c = 0; c < N; c++) xv[c*DW +: DW] = DW'(-32768);
        accept_vector(xv);
        wait_result(lat);
        for (int r = 0; r < N; r++) begin
            e = convert(model_dot(r, xv));
            total++;
            if (s_out[r*OUT_W +: OUT_W] !== OUT_W'(e)) begin
                bad++; $display("[TB] FAIL overflow_s%0d got=%0d want=%0d", r, $signed(s_out[r*OUT_W +: OUT_W]), e);
            end
            total++;
            if (sat[r] !== expect_sat(model_dot(r, xv))) begin
                bad++; $display("[TB] FAIL overflow_sat%0d got=%b want=%b", r, sat[r], expect_sat(model_dot(r, xv)));
            end
        end
        consume();
    endtask

    task automatic test_same_cycle_write();
        logic [N*DW-1:0] xv;
        logic [DW-1:0]   v;
        longint e;
        int lat;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mw[r][c] = longint'($signed(DW'($urandom)));
        push_weights();
        xv = rand_vec();
        v = DW'($urandom);
        mw[1][2] = longint'($signed(v));
        @(negedge clk);
        x_valid = 1'b1; x_in = xv;
        w_we = 1'b1; w_row = AW'(1); w_col = AW'(2); w_data = v;
        @(posedge clk);
        @(negedge clk);
        x_valid = 1'b0; w_we = 1'b0;
        total++; if (w_err !== 1'b0) begin bad++; $display("[TB] FAIL samecycle_w_err got=%b want=0", w_err); end
        wait_result(lat);
        total++; if (lat !== N) begin bad++; $display("[TB] FAIL samecycle_latency got=%0d want=%0d", lat, N); end
        for (int r = 0; r < N; r++) begin
            e = convert(model_dot(r, xv));
            total++;
            if (s_out[r*OUT_W +: OUT_W] !== OUT_W'(e)) begin
                bad++; $display("[TB] FAIL samecycle_s%0d got=%0d want=%0d", r, $signed(s_out[r*OUT_W +: OUT_W]), e);
            end
        end
        consume();
    endtask

    task automatic test_write_drop();
        logic [N*DW-1:0] xv;
        longint e;
        int lat;
        xv = rand_vec();
        accept_vector(xv);
        w_we = 1'b1; w_row = '0; w_col = '0; w_data = ~DW'(mw[0][0]);
        @(negedge clk);
        w_we = 1'b0;
        total++; if (w_err !== 1'b1) begin bad++; $display("[TB] FAIL drop_mac_pulse got=%b want=1", w_err); end
        @(negedge clk);
        total++; if (w_err !== 1'b0) begin bad++; $display("[TB] FAIL drop_mac_clear got=%b want=0", w_err); end
        wait_result(lat);
        for (int r = 0; r < N; r++) begin
            e = convert(model_dot(r, xv));
            total++;
            if (s_out[r*OUT_W +: OUT_W] !== OUT_W'(e)) begin
                bad++; $display("[TB] FAIL drop_mac_s%0d got=%0d want=%0d", r, $signed(s_out[r*OUT_W +: OUT_W]), e);
            end
        end
        consume();
        w_we = 1'b1; w_row = AW'(N); w_col = '0; w_data = DW'($urandom);
        @(negedge clk);
        w_we = 1'b0;
        total++; if (w_err !== 1'b1) begin bad++; $display("[TB] FAIL drop_row_pulse got=%b want=1", w_err); end
        @(negedge clk);
        total++; if (w_err !== 1'b0) begin bad++; $display("[TB] FAIL drop_row_clear got=%b want=0", w_err); end
        xv = rand_vec();
        accept_vector(xv);
        wait_result(lat);
        for (int r = 0; r < N; r++) begin
            e = convert(model_dot(r, xv));
            total++;
            if (s_out[r*OUT_W +: OUT_W] !== OUT_W'(e)) begin
                bad++; $display("[TB] FAIL drop_row_s%0d got=%0d want=%0d", r, $signed(s_out[r*OUT_W +: OUT_W]), e);
            end
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [N*DW-1:0] vecs [2];
        int   acc_at [2];
        int   nacc;
        int   nres;
        logic take;
        longint e;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mw[r][c] = longint'($signed(DW'($urandom)));
        push_weights();
        vecs[0] = rand_vec();
        vecs[1] = rand_vec();
        acc_at[0] = 0; acc_at[1] = -100;
        nacc = 0; nres = 0;
        @(negedge clk);
        s_ready = 1'b1; x_valid = 1'b1; x_in = vecs[0];
        for (int it = 0; it < 60 && nres < 2; it++) begin
            if (s_valid) begin
                for (int r = 0; r < N; r++) begin
                    e = convert(model_dot(r, vecs[nres]));
                    total++;
                    if (s_out[r*OUT_W +: OUT_W] !== OUT_W'(e)) begin
                        bad++; $display("[TB] FAIL b2b_v%0d_s%0d got=%0d want=%0d", nres, r, $signed(s_out[r*OUT_W +: OUT_W]), e);
                    end
                end
                nres++;
            end
            take = x_valid && x_ready;
            @(posedge clk);
            #1;
            if (take) begin
                acc_at[nacc] = it;
                nacc++;
                if (nacc < 2) x_in = vecs[1];
                else x_valid = 1'b0;
            end
            @(negedge clk);
        end
        s_ready = 1'b0; x_valid = 1'b0;
        total++; if (nres !== 2) begin bad++; $display("[TB] FAIL b2b_results got=%0d want=2", nres); end
        total++; if (acc_at[1] - acc_at[0] !== N + 2) begin
            bad++; $display("[TB] FAIL b2b_spacing got=%0d want=%0d", acc_at[1] - acc_at[0], N + 2);
        end
    endtask

    task automatic test_reset_mid_mac();
        logic [N*DW-1:0] xv;
        int lat;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mw[r][c] = longint'($signed(DW'($urandom | 1)));
        push_weights();
        xv = rand_vec();
        accept_vector(xv);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mw[r][c] = 0;
        total++; if (x_ready !== 1'b1 || s_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL midreset_state got=%b%b want=10", x_ready, s_valid);
        end
        total++; if (s_out !== '0) begin bad++; $display("[TB] FAIL midreset_s_out got=%h want=0", s_out); end
        xv = rand_vec();
        xv[0 +: DW] = xv[0 +: DW] | DW'(1);
        accept_vector(xv);
        wait_result(lat);
        for (int r = 0; r < N; r++) begin
            total++;
            if (s_out[r*OUT_W +: OUT_W] !== OUT_W'(convert(model_dot(r, xv)))) begin
                bad++; $display("[TB] FAIL midreset_s%0d got=%0d want=%0d", r, $signed(s_out[r*OUT_W +: OUT_W]), convert(model_dot(r, xv)));
            end
        end
        consume();
    endtask

    initial begin
        $display("[TB] wx_matvec bench start, SAT_EN=%0d", SAT_EN);
        test_reset();
        test_identity();
        test_stall();
        test_overflow();
        test_same_cycle_write();
        test_write_drop();
        test_back_to_back();
        test_reset_mid_mac();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
